// File: rtl/receiver_physical_word_align.sv
// receiver_physical_word_align
// Sits between the ISERDES and the 8b10b decoder. Raw 10-bit words arrive
// with an unknown bit rotation; the block searches all ten rotations for
// the K28.5 comma, locks after repeated commas at one rotation, and then
// delivers aligned symbols. Lock is dropped on sustained decoder errors or
// misaligned commas.

module receiver_physical_word_align #(
  parameter int LOCK_COMMAS   = 4,
  parameter int TIMEOUT_WORDS = 256,
  parameter int ERR_LIMIT     = 4,
  parameter int ERR_WINDOW    = 64
) (
  input  logic       i_clk_120,
  input  logic       i_clk_120_rst_n,
  input  logic [9:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_code_err,
  output logic [9:0] o_symbol,
  output logic       o_symbol_valid,
  output logic       o_comma,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int CC_W = $clog2(LOCK_COMMAS) + 1;
  localparam int TO_W = $clog2(TIMEOUT_WORDS) + 1;
  localparam int EC_W = $clog2(ERR_LIMIT) + 1;
  localparam int WC_W = $clog2(ERR_WINDOW) + 1;

  localparam logic [CC_W-1:0] CC_LOCK = CC_W'(LOCK_COMMAS);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_WORDS);
  localparam logic [EC_W-1:0] EC_LIM  = EC_W'(ERR_LIMIT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(ERR_WINDOW - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Registered state
  state_t          state_q, state_d;
  logic [3:0]      offset_q, offset_d;
  logic [9:0]      prev_word_q, prev_word_d;
  logic [CC_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [EC_W-1:0] err_cnt_q, err_cnt_d;
  logic [WC_W-1:0] win_cnt_q, win_cnt_d;

  // Registered outputs
  logic [9:0]      symbol_q, symbol_d;
  logic            symbol_valid_q, symbol_valid_d;
  logic            comma_q, comma_d;
  logic            locked_q, locked_d;

  // Comma search results for the current window
  logic [19:0]     window;
  logic [9:0]      cand [10];
  logic [9:0]      comma_hit;
  logic [3:0]      first_hit;
  logic            any_hit;
  logic [9:0]      sel_cand;
  logic            hit_here;
  logic            hit_else;

  // Helper terms for the counters
  logic            enter_hunt;
  logic            err_word;
  logic [EC_W-1:0] err_sum;

  // Slice the 20-bit window into all ten candidates and flag commas in each.
  always_comb begin
    window    = {prev_word_q, i_data};
    comma_hit = '0;
    first_hit = '0;
    any_hit   = 1'b0;
    sel_cand  = '0;
    hit_here  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cand[k]      = window[19-k -: 10];
      comma_hit[k] = (cand[k][9:3] == 7'b0011111) || (cand[k][9:3] == 7'b1100000);
    end
    // Scanning downwards leaves the lowest matching offset in first_hit.
    for (int k = 9; k >= 0; k--) begin
      if (comma_hit[k]) begin
        first_hit = 4'(k);
        any_hit   = 1'b1;
      end
    end
    for (int k = 0; k < 10; k++) begin
      if (offset_q == 4'(k)) begin
        sel_cand = cand[k];
        hit_here = comma_hit[k];
      end
    end
    hit_else = any_hit & ~hit_here;
  end

  // Next-state and counter logic; nothing moves on idle cycles.
  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    prev_word_d   = prev_word_q;
    comma_cnt_d   = comma_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    err_cnt_d     = err_cnt_q;
    win_cnt_d     = win_cnt_q;
    enter_hunt    = 1'b0;
    err_word      = i_code_err | hit_else;
    err_sum       = err_cnt_q + EC_W'(err_word);

    if (i_data_valid) begin
      prev_word_d = i_data;
      unique case (state_q)
        ST_HUNT: begin
          if (any_hit) begin
            offset_d      = first_hit;
            comma_cnt_d   = CC_W'(1);
            timeout_cnt_d = '0;
            state_d       = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (hit_here) begin
            comma_cnt_d   = comma_cnt_q + CC_W'(1);
            timeout_cnt_d = '0;
            if (comma_cnt_q + CC_W'(1) == CC_LOCK) begin
              state_d = ST_LOCKED;
            end
          end else if (hit_else) begin
            enter_hunt = 1'b1;
          end else begin
            timeout_cnt_d = timeout_cnt_q + TO_W'(1);
            if (timeout_cnt_q + TO_W'(1) == TO_LIM) begin
              enter_hunt = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          // Reaching the error limit wins over a window wrap on the same word.
          if (err_sum == EC_LIM) begin
            enter_hunt = 1'b1;
          end else if (win_cnt_q == WC_LAST) begin
            win_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WC_W'(1);
            err_cnt_d = err_sum;
          end
        end
        default: begin
          enter_hunt = 1'b1;
        end
      endcase

      // Returning to HUNT discards all progress but keeps the last offset.
      if (enter_hunt) begin
        state_d       = ST_HUNT;
        comma_cnt_d   = '0;
        timeout_cnt_d = '0;
        err_cnt_d     = '0;
        win_cnt_d     = '0;
      end
    end
  end

  // Output values: the symbol at the held offset, qualified by the lock state
  // on both sides of the edge so valid drops together with o_locked.
  always_comb begin
    symbol_d       = symbol_q;
    comma_d        = comma_q;
    symbol_valid_d = 1'b0;
    if (i_data_valid) begin
      symbol_d       = sel_cand;
      comma_d        = hit_here;
      symbol_valid_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk_120) begin
    if (!i_clk_120_rst_n) begin
      state_q        <= ST_HUNT;
      offset_q       <= '0;
      prev_word_q    <= '0;
      comma_cnt_q    <= '0;
      timeout_cnt_q  <= '0;
      err_cnt_q      <= '0;
      win_cnt_q      <= '0;
      symbol_q       <= '0;
      symbol_valid_q <= 1'b0;
      comma_q        <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      offset_q       <= offset_d;
      prev_word_q    <= prev_word_d;
      comma_cnt_q    <= comma_cnt_d;
      timeout_cnt_q  <= timeout_cnt_d;
      err_cnt_q      <= err_cnt_d;
      win_cnt_q      <= win_cnt_d;
      symbol_q       <= symbol_d;
      symbol_valid_q <= symbol_valid_d;
      comma_q        <= comma_d;
      locked_q       <= locked_d;
    end
  end

  assign o_symbol       = symbol_q;
  assign o_symbol_valid = symbol_valid_q;
  assign o_comma        = comma_q;
  assign o_locked       = locked_q;
  assign o_offset       = offset_q;

endmodule

// File: tb/tb_receiver_physical_word_align.sv
// Testbench for receiver_physical_word_align: directed comma streams at each
// rotation, CHECK/LOCKED boundary cases and a randomized phase, all compared
// against a word-level reference model of the aligner rules.

module tb_receiver_physical_word_align;

  localparam int LOCK_COMMAS   = 4;
  localparam int TIMEOUT_WORDS = 256;
  localparam int ERR_LIMIT     = 4;
  localparam int ERR_WINDOW    = 64;

  localparam logic [9:0] K_NEG  = 10'b0011111010;
  localparam logic [9:0] K_POS  = 10'b1100000101;
  localparam logic [9:0] D_FILL = 10'b1010101010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] data = '0;
  logic       valid = 1'b0;
  logic       code_err = 1'b0;
  logic [9:0] o_symbol;
  logic       o_symbol_valid;
  logic       o_comma;
  logic       o_locked;
  logic [3:0] o_offset;

  int checks = 0;
  int failures = 0;

  // Reference model state
  string      m_mode;
  logic [9:0] m_prev;
  int         m_off, m_commas, m_quiet, m_errs, m_pos;
  logic [9:0] e_sym;
  bit         e_valid, e_comma, e_locked;
  int         e_off;

  bit         bq[$];

  always #5 clk = ~clk;

  receiver_physical_word_align #(
    .LOCK_COMMAS(LOCK_COMMAS), .TIMEOUT_WORDS(TIMEOUT_WORDS),
    .ERR_LIMIT(ERR_LIMIT), .ERR_WINDOW(ERR_WINDOW)
  ) dut (
    .i_clk_120(clk),
    .i_clk_120_rst_n(rst_n),
    .i_data(data),
    .i_data_valid(valid),
    .i_code_err(code_err),
    .o_symbol(o_symbol),
    .o_symbol_valid(o_symbol_valid),
    .o_comma(o_comma),
    .o_locked(o_locked),
    .o_offset(o_offset)
  );

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit isComma(input logic [9:0] c);
    return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
  endfunction

  // Candidate k is the 10 bits starting k bits into the older word.
  function automatic logic [9:0] candAt(input logic [19:0] w, input int k);
    logic [19:0] s;
    s = w >> (10 - k);
    return s[9:0];
  endfunction

  // Alternating filler with one comma character placed at rotation k.
  function automatic logic [19:0] makePair(input int k, input logic [9:0] kc);
    logic [19:0] w;
    w = 20'hAAAAA;
    w[19-k -: 10] = kc;
    return w;
  endfunction

  task automatic modelHunt();
    m_mode   = "HUNT";
    m_commas = 0;
    m_quiet  = 0;
    m_errs   = 0;
    m_pos    = 0;
  endtask

  task automatic modelReset();
    modelHunt();
    m_prev   = '0;
    m_off    = 0;
    e_sym    = '0;
    e_valid  = 1'b0;
    e_comma  = 1'b0;
    e_locked = 1'b0;
    e_off    = 0;
  endtask

  // One valid word through the alignment rules.
  task automatic modelWord(input logic [9:0] d, input bit err);
    logic [19:0] w;
    int          hits[$];
    bit          here, elsewhere, was_locked;
    w = {m_prev, d};
    for (int k = 0; k < 10; k++) if (isComma(candAt(w, k))) hits.push_back(k);
    here       = isComma(candAt(w, m_off));
    elsewhere  = (hits.size() > 0) && !here;
    e_sym      = candAt(w, m_off);
    e_comma    = here;
    was_locked = (m_mode == "LOCKED");
    m_prev     = d;
    if (m_mode == "HUNT") begin
      if (hits.size() > 0) begin
        m_off    = hits[0];
        m_commas = 1;
        m_quiet  = 0;
        m_mode   = "CHECK";
      end
    end else if (m_mode == "CHECK") begin
      if (here) begin
        m_commas++;
        m_quiet = 0;
        if (m_commas == LOCK_COMMAS) m_mode = "LOCKED";
      end else if (elsewhere) begin
        modelHunt();
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT_WORDS) modelHunt();
      end
    end else begin
      if (err || elsewhere) m_errs++;
      if (m_errs == ERR_LIMIT) begin
        modelHunt();
      end else begin
        m_pos++;
        if (m_pos == ERR_WINDOW) begin
          m_pos  = 0;
          m_errs = 0;
        end
      end
    end
    e_locked = (m_mode == "LOCKED");
    e_valid  = was_locked && e_locked;
    e_off    = m_off;
  endtask

  // Drive one cycle, advance the model, then compare every output.
  task automatic applyStimulus(input bit v, input logic [9:0] d, input bit e, input bit rn);
    valid    = v;
    data     = d;
    code_err = e;
    rst_n    = rn;
    if (!rn) modelReset();
    else if (v) modelWord(d, e);
    else e_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("symbol", 32'(o_symbol), 32'(e_sym));
    checkOutput("symbol_valid", 32'(o_symbol_valid), 32'(e_valid));
    checkOutput("comma", 32'(o_comma), 32'(e_comma));
    checkOutput("locked", 32'(o_locked), 32'(e_locked));
    checkOutput("offset", 32'(o_offset), 32'(e_off));
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    bq.delete();
  endtask

  task automatic pushBits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  task automatic pushPairs(input int n);
    repeat (n) begin
      pushBits(K_NEG, 10);
      pushBits(D_FILL, 10);
      pushBits(K_POS, 10);
      pushBits(D_FILL, 10);
    end
  endtask

  // Emit every complete raw word in the bit queue, optionally with idle gaps.
  task automatic sendQueued(input bit gaps);
    while (bq.size() >= 10) begin
      logic [9:0] w;
      for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
      if (gaps && $urandom_range(0, 3) == 0) applyStimulus(1'b0, 10'($urandom), 1'b0, 1'b1);
      applyStimulus(1'b1, w, 1'b0, 1'b1);
    end
  endtask

  task automatic randomWord(input logic [9:0] d);
    if ($urandom_range(0, 4) == 0)
      applyStimulus(1'b0, 10'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    applyStimulus(1'b1, d, $urandom_range(0, 15) == 0, 1'b1);
  endtask

  // Aligned K28.5 stream (rotation 0) sent one word per call, until the model locks.
  task automatic lockAtZero();
    logic [9:0] seq [4];
    seq[0] = K_NEG; seq[1] = D_FILL; seq[2] = K_POS; seq[3] = D_FILL;
    for (int i = 0; i < 40 && !e_locked; i++) applyStimulus(1'b1, seq[i % 4], 1'b0, 1'b1);
    checkOutput("lockReached", 32'(o_locked), 32'd1);
  endtask

  initial begin
    int cur_k;
    logic [19:0] pr;
    logic [9:0] seq [4];
    seq[0] = K_NEG; seq[1] = D_FILL; seq[2] = K_POS; seq[3] = D_FILL;
    modelReset();

    // Reset state
    resetDut();
    checkOutput("resetLocked", 32'(o_locked), 32'd0);
    checkOutput("resetSymbol", 32'(o_symbol), 32'd0);

    // Rotation sweep, including the offset-3 stream
    for (int k = 0; k < 10; k++) begin
      resetDut();
      pushBits(D_FILL, (k == 0) ? 10 : k);
      pushBits(D_FILL, 10);
      pushPairs(3);
      pushBits(D_FILL, 10);
      sendQueued(k == 3);
      checkOutput("sweepLocked", 32'(o_locked), 32'd1);
      checkOutput("sweepOffset", 32'(o_offset), 32'(k));
    end

    // Two commas at rotation 5, then the stream slips to rotation 2
    resetDut();
    pushBits(D_FILL, 5);
    pushBits(D_FILL, 10);
    pushBits(K_NEG, 10);
    pushBits(D_FILL, 10);
    pushBits(K_POS, 10);
    pushBits(D_FILL, 10);
    sendQueued(1'b0);
    checkOutput("shiftPreOffset", 32'(o_offset), 32'd5);
    checkOutput("shiftPreLocked", 32'(o_locked), 32'd0);
    pushBits(D_FILL, 7);
    pushBits(D_FILL, 10);
    pushPairs(3);
    pushBits(D_FILL, 10);
    sendQueued(1'b0);
    checkOutput("shiftLocked", 32'(o_locked), 32'd1);
    checkOutput("shiftOffset", 32'(o_offset), 32'd2);

    // Error window: 3 errors in window 0 hold lock, 4 in window 1 drop it
    resetDut();
    lockAtZero();
    for (int li = 0; li < 91; li++) begin
      bit e;
      e = (li == 5) || (li == 20) || (li == 40) || (li == 70) ||
          (li == 75) || (li == 80) || (li == 85);
      applyStimulus(1'b1, seq[li % 4], e, 1'b1);
      if (li == 69) checkOutput("errWin1Hold", 32'(o_locked), 32'd1);
      if (li == 84) checkOutput("errWin2Third", 32'(o_locked), 32'd1);
      if (li == 85) begin
        checkOutput("errWin2Drop", 32'(o_locked), 32'd0);
        checkOutput("errWin2Valid", 32'(o_symbol_valid), 32'd0);
      end
    end

    // CHECK timeout boundary: 255 quiet words keep CHECK, 256 return to HUNT
    for (int quiet = 255; quiet <= 256; quiet++) begin
      resetDut();
      applyStimulus(1'b1, D_FILL, 1'b0, 1'b1);
      applyStimulus(1'b1, D_FILL, 1'b0, 1'b1);
      pr = makePair(4, K_NEG);
      applyStimulus(1'b1, pr[19:10], 1'b0, 1'b1);
      applyStimulus(1'b1, pr[9:0], 1'b0, 1'b1);
      checkOutput("toEntryOffset", 32'(o_offset), 32'd4);
      repeat (quiet - 1) applyStimulus(1'b1, D_FILL, 1'b0, 1'b1);
      pr = makePair(7, K_NEG);
      applyStimulus(1'b1, pr[19:10], 1'b0, 1'b1);
      applyStimulus(1'b1, pr[9:0], 1'b0, 1'b1);
      checkOutput("toOffset", 32'(o_offset), (quiet == TIMEOUT_WORDS) ? 32'd7 : 32'd4);
      checkOutput("toLocked", 32'(o_locked), 32'd0);
    end

    // Valid gaps while locked, then a one-cycle reset
    resetDut();
    lockAtZero();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, seq[i % 4], 1'b0, 1'b1);
      checkOutput("gapValidHigh", 32'(o_symbol_valid), 32'd1);
      applyStimulus(1'b0, 10'($urandom), 1'b0, 1'b1);
      checkOutput("gapValidLow", 32'(o_symbol_valid), 32'd0);
    end
    applyStimulus(1'b1, K_NEG, 1'b0, 1'b0);
    checkOutput("midRstLocked", 32'(o_locked), 32'd0);
    checkOutput("midRstSymbol", 32'(o_symbol), 32'd0);
    checkOutput("midRstOffset", 32'(o_offset), 32'd0);
    applyStimulus(1'b1, D_FILL, 1'b0, 1'b1);
    checkOutput("postRstLocked", 32'(o_locked), 32'd0);

    // Randomized phase against the model
    cur_k = $urandom_range(0, 9);
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 59) == 0) applyStimulus(1'b0, 10'($urandom), 1'b0, 1'b0);
      if ($urandom_range(0, 7) == 0) cur_k = $urandom_range(0, 9);
      pr = makePair(cur_k, ($urandom_range(0, 1) == 1) ? K_NEG : K_POS);
      randomWord(pr[19:10]);
      randomWord(pr[9:0]);
      repeat ($urandom_range(0, 2))
        randomWord(($urandom_range(0, 3) == 0) ? 10'($urandom) : D_FILL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/receiver_physical_word_align.md
# receiver_physical_word_align

Receive-side symbol aligner for the LVDS link, placed between the ISERDES deserializer and the 8b10b decoder in the physical receiver. It takes raw 10-bit words of unknown bit rotation and searches all 10 offsets for the K28.5 comma. It locks onto the offset after repeated commas and then delivers aligned 10-bit symbols. Lock is dropped on sustained decoder errors or misaligned commas.

## Interface
Parameters:
- LOCK_COMMAS, 4: commas required at one offset before lock (2..15).
- TIMEOUT_WORDS, 256: valid words allowed in CHECK without a comma before returning to HUNT.
- ERR_LIMIT, 4: error words within one window that force loss of lock.
- ERR_WINDOW, 64: length of the error window, in valid words.

Ports:
- i_clk_120, in, 1: only clock. Reset is synchronous and active-low.
- i_clk_120_rst_n, in, 1: synchronous active-low reset.
- i_data, in, 10: raw deserialized word. Bit 9 is the earliest received bit.
- i_data_valid, in, 1: i_data is valid this cycle.
- i_code_err, in, 1: code or disparity error reported by the downstream decoder for the previous symbol.
- o_symbol, out, 10: aligned symbol. Bit 9 is bit "a" of abcdeifghj.
- o_symbol_valid, out, 1: o_symbol is valid. Asserted only while LOCKED.
- o_comma, out, 1: o_symbol contains a comma at the locked offset.
- o_locked, out, 1: state is LOCKED.
- o_offset, out, 4: current bit offset, 0..9.

## Operation
- Window: w = {prev_word, i_data}, 20 bits. prev_word updates only on i_data_valid. The candidate at offset k is cand_k = w[19-k -: 10], for k = 0..9.
- Comma detect: cand_k[9:3] == 7'b0011111 or 7'b1100000.
- All state, counters, prev_word and offset advance only on i_data_valid cycles. Idle cycles hold everything.
- FSM:
  - HUNT: if any candidate has a comma, load offset with the lowest such k, set comma_cnt = 1 and go to CHECK.
  - CHECK: a comma at the locked offset increments comma_cnt and clears the timeout counter. A comma at any other offset, with none at the locked offset, returns to HUNT. When comma_cnt reaches LOCK_COMMAS, go to LOCKED. If TIMEOUT_WORDS valid words pass without a comma, return to HUNT.
  - LOCKED: a word is an error word if i_code_err = 1, or a comma is seen at a non-locked offset while none is seen at the locked offset. Each word adds at most +1 to err_cnt. win_cnt counts valid words and, at ERR_WINDOW-1, wraps to 0 and clears err_cnt. When err_cnt reaches ERR_LIMIT, go to HUNT. This takes precedence over a window clear in the same cycle.
- Entering HUNT clears comma_cnt, err_cnt, win_cnt and the timeout counter. Offset holds its last value.
- Counter widths are $clog2 of their limit plus 1. Counters never wrap past their limit.
- Reset, taken on a clock edge with i_clk_120_rst_n = 0, produces:
  - state HUNT, offset 0, prev_word 0;
  - all counters 0;
  - o_symbol 0, o_symbol_valid 0, o_comma 0, o_locked 0, o_offset 0.
- Reset in any state, mid-operation, returns to these values on the next edge. No partial lock survives.

## Timing
- All outputs are registered.
- If word W arrives with i_data_valid at edge t, then after edge t+1:
  - o_symbol = cand_offset({prev, W}), using the offset held before edge t;
  - o_comma reflects that candidate;
  - o_symbol_valid = 1 only if the state at edge t was LOCKED.
- Latency is 1 cycle from i_data to o_symbol.
- o_locked rises in the cycle after the edge that consumes the LOCK_COMMAS-th comma. The first o_symbol_valid appears with the next valid word.
- Loss of lock: o_locked and o_symbol_valid fall in the cycle after the edge that reaches ERR_LIMIT.
- Valid gaps: o_symbol_valid = 0 whenever the input valid was 0. o_symbol holds its value.
- No backpressure. Output throughput equals input throughput.

## Test plan
- Rotated comma stream at offset 3: repeat the K28.5 RD- pair 0011111010 / 1100000101, bit-rotated by 3, with data words in between. Required: o_offset = 3, o_locked = 1 after the 4th comma, and o_symbol equals the unrotated symbols with 1-cycle latency.
- Offset sweep 0..9: for each k, reset and then stream commas at offset k. Required: lock with o_offset = k. In the k = 0 case, the symbol data contains no false comma at a lower offset.
- Comma at a shifted offset in CHECK: two commas at offset 5, then one at offset 2. Required: return to HUNT, then re-lock at offset 2 after 4 commas.
- Error window in LOCKED: pulse i_code_err 3 times within 64 words. Required: stays locked. After a window wrap, pulse 4 times within one window. Required: o_locked = 0 one cycle after the 4th pulse.
- CHECK timeout: 1 comma, then 256 valid words without a comma. Required: back to HUNT, o_locked stays 0.
- Reset mid-lock plus valid gaps: i_data_valid alternating 1/0 while locked keeps o_symbol_valid aligned to valid input. Asserting i_clk_120_rst_n = 0 for 1 cycle clears all outputs to 0 on the next edge.
